// File: rtl/parity_engine_scheduler.sv
// Round-robin scheduler that time-shares one external Moore toggle/parity engine
// among NREQ serial requesters, one BURST-bit transaction per grant.
module parity_engine_scheduler #(
  parameter int NREQ  = 4,
  parameter int BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] din_bus_i,
  output logic [NREQ-1:0] grant_o,
  output logic            take_o,
  output logic            eng_rst_o,
  output logic            eng_din_o,
  input  logic            eng_dout_i,
  output logic            done_o,
  output logic [2:0]      done_id_o,
  output logic            result_o
);

  localparam int CW = $clog2(BURST);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRIME,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      owner_q;
  logic [2:0]      ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] grant_q;

  logic [2:0]      ptrWrap;
  logic [2:0]      arbPtr;
  logic [3:0]      candIdx;
  logic            reqFound;
  logic [2:0]      owner_d;
  logic [NREQ-1:0] grant_d;

  assign ptrWrap = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;

  // In DONE the search starts just past the outgoing owner, so the ptr_q update
  // made on that same edge is not yet visible and is bypassed here.
  assign arbPtr = (state_q == DONE) ? ptrWrap : ptr_q;

  // Scan from the highest offset down so the lowest offset from arbPtr wins.
  always_comb begin
    reqFound = 1'b0;
    owner_d  = '0;
    candIdx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      candIdx = {1'b0, arbPtr} + 4'(i);
      if (candIdx >= 4'(NREQ)) begin
        candIdx = candIdx - 4'(NREQ);
      end
      if (req_i[candIdx[IW-1:0]]) begin
        reqFound = 1'b1;
        owner_d  = candIdx[2:0];
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int j = 0; j < NREQ; j++) begin
      grant_d[j] = reqFound && (owner_d == 3'(j));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqFound) begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= PRIME;
        end
        PRIME: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q <= ptrWrap;
          if (reqFound) begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            state_q <= CLEAR;
          end else begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reset is synchronous, so outputs are masked while rst is high to keep them
  // quiet even in the cycle before the state register has been cleared.
  assign grant_o   = rst ? '0 : grant_q;
  assign take_o    = !rst && (state_q == RUN);
  assign eng_rst_o = rst || (state_q == CLEAR);
  assign eng_din_o = take_o && |(din_bus_i & grant_q);
  assign done_o    = !rst && (state_q == DONE);
  assign done_id_o = done_o ? owner_q : 3'd0;
  assign result_o  = done_o && eng_dout_i;

endmodule

// File: tb/tb_parity_engine_scheduler.sv
// Directed bench for parity_engine_scheduler: models the Moore parity engine and
// the serial requesters, and checks each transaction against hand-computed values.
module tb_parity_engine_scheduler;

  localparam int NREQ  = 4;
  localparam int BURST = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din_bus;
  logic [NREQ-1:0] grant;
  logic            take;
  logic            eng_rst;
  logic            eng_din;
  logic            eng_dout;
  logic            done;
  logic [2:0]      done_id;
  logic            result;

  int errors = 0;
  int checks = 0;

  // Requester bit streams are LSB-first; engine state 0=idle, 1=even, 2=odd.
  logic [15:0] pat [NREQ];
  int          bitIdx [NREQ];
  logic [1:0]  engState;

  assign eng_dout = (engState == 2'd2);

  always #5 clk = ~clk;

  parity_engine_scheduler #(.NREQ(NREQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .din_bus_i (din_bus),
    .grant_o   (grant),
    .take_o    (take),
    .eng_rst_o (eng_rst),
    .eng_din_o (eng_din),
    .eng_dout_i(eng_dout),
    .done_o    (done),
    .done_id_o (done_id),
    .result_o  (result)
  );

  task automatic refreshDin();
    for (int i = 0; i < NREQ; i++) begin
      din_bus[i] = (bitIdx[i] < 16) ? pat[i][bitIdx[i][3:0]] : 1'b0;
    end
  endtask

  task automatic setPat(input int id, input logic [15:0] value);
    pat[id]    = value;
    bitIdx[id] = 0;
    refreshDin();
  endtask

  // Advance one clock: sample DUT at the negedge, update engine and requesters
  // just after the posedge, and return at the following negedge.
  task automatic step();
    logic [NREQ-1:0] consume;
    logic er;
    logic ed;
    consume = take ? grant : '0;
    er = eng_rst;
    ed = eng_din;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (consume[i]) bitIdx[i]++;
    end
    if (er) engState = 2'd0;
    else if (engState == 2'd0) engState = 2'd1;
    else if (ed) engState = (engState == 2'd1) ? 2'd2 : 2'd1;
    refreshDin();
    @(negedge clk);
  endtask

  task automatic waitDone(input int dropAt, output int k, output int takes,
                          output int clears, output logic firstRst,
                          output logic [NREQ-1:0] firstGrant);
    k = 0;
    takes = 0;
    clears = 0;
    firstRst = 1'b0;
    firstGrant = '0;
    do begin
      step();
      k++;
      if (k == 1) begin
        firstRst = eng_rst;
        firstGrant = grant;
      end
      if (take) takes++;
      if (eng_rst) clears++;
      if (dropAt > 0 && take && takes == dropAt) req = '0;
    end while (done !== 1'b1 && k < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (take !== 1'b0) begin errors++; $display("[TB] FAIL reset_take: got %b want 0", take); end
    checks++; if (done !== 1'b0 || done_id !== 3'd0 || result !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got done=%b id=%0d res=%b want 0/0/0", done, done_id, result); end
    checks++; if (eng_rst !== 1'b1 || eng_din !== 1'b0) begin errors++; $display("[TB] FAIL reset_eng: got rst=%b din=%b want 1/0", eng_rst, eng_din); end
    rst = 1'b0;
    step();
    checks++; if (eng_rst !== 1'b0 || grant !== 4'b0000) begin errors++; $display("[TB] FAIL idle_after_reset: got eng_rst=%b grant=%b want 0/0000", eng_rst, grant); end
  endtask

  task automatic test_single();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    setPat(0, 16'h000D);  // bits 1,0,1,1,0,0,0,0
    req = 4'b0001;
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (k !== 11) begin errors++; $display("[TB] FAIL single_latency: got %0d want 11", k); end
    checks++; if (takes !== 8) begin errors++; $display("[TB] FAIL single_takes: got %0d want 8", takes); end
    checks++; if (clears !== 1 || fr !== 1'b1) begin errors++; $display("[TB] FAIL single_clear: got count=%0d first=%b want 1/1", clears, fr); end
    checks++; if (fg !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b want 0001", fg); end
    checks++; if (done_id !== 3'd0 || result !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got id=%0d res=%b want 0/1", done_id, result); end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000 || take !== 1'b0 || eng_rst !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got grant=%b take=%b eng_rst=%b want 0000/0/0", grant, take, eng_rst); end
    checks++; if (done !== 1'b0 || result !== 1'b0) begin errors++; $display("[TB] FAIL single_result_masked: got done=%b res=%b want 0/0", done, result); end
    step();
    checks++; if (take !== 1'b0 || grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_stay_idle: got take=%b grant=%b want 0/0000", take, grant); end
  endtask

  task automatic test_even_parity();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    setPat(2, 16'h00C3);  // bits 1,1,0,0,0,0,1,1
    req = 4'b0100;
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (k !== 11 || fg !== 4'b0100) begin errors++; $display("[TB] FAIL even_txn: got k=%0d grant=%b want 11/0100", k, fg); end
    checks++; if (done_id !== 3'd2 || result !== 1'b0) begin errors++; $display("[TB] FAIL even_done: got id=%0d res=%b want 2/0", done_id, result); end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL even_release: got %b want 0000", grant); end
  endtask

  task automatic test_round_robin();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    int expId [5] = '{0, 1, 2, 3, 0};
    logic expRes [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    setPat(0, 16'h0307);
    setPat(1, 16'h0001);
    setPat(2, 16'h0003);
    setPat(3, 16'h00F1);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitDone(0, k, takes, clears, fr, fg);
      checks++; if (done_id !== 3'(expId[n]) || result !== expRes[n]) begin errors++; $display("[TB] FAIL rr_done%0d: got id=%0d res=%b want %0d/%b", n, done_id, result, expId[n], expRes[n]); end
      checks++; if (k !== 11 || fr !== 1'b1 || takes !== 8) begin errors++; $display("[TB] FAIL rr_timing%0d: got k=%0d clear=%b takes=%0d want 11/1/8", n, k, fr, takes); end
      checks++; if (fg !== (4'b0001 << expId[n])) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want id %0d", n, fg, expId[n]); end
    end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rr_release: got %b want 0000", grant); end
  endtask

  task automatic test_fairness();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    setPat(3, 16'h0301);
    setPat(0, 16'h000F);
    req = 4'b1000;
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (done_id !== 3'd3 || result !== 1'b1) begin errors++; $display("[TB] FAIL wrap_first: got id=%0d res=%b want 3/1", done_id, result); end
    req = 4'b1001;
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (done_id !== 3'd0 || result !== 1'b0 || fg !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_to0: got id=%0d res=%b grant=%b want 0/0/0001", done_id, result, fg); end
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (done_id !== 3'd3 || result !== 1'b0 || fg !== 4'b1000 || k !== 11) begin errors++; $display("[TB] FAIL wrap_to3: got id=%0d res=%b grant=%b k=%0d want 3/0/1000/11", done_id, result, fg, k); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_drop_mid_burst();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    setPat(1, 16'h0007);
    req = 4'b0010;
    waitDone(4, k, takes, clears, fr, fg);
    checks++; if (k !== 11 || takes !== 8) begin errors++; $display("[TB] FAIL drop_complete: got k=%0d takes=%0d want 11/8", k, takes); end
    checks++; if (done_id !== 3'd1 || result !== 1'b1) begin errors++; $display("[TB] FAIL drop_done: got id=%0d res=%b want 1/1", done_id, result); end
    step();
    step();
    step();
    checks++; if (grant !== 4'b0000 || take !== 1'b0 || eng_rst !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_regrant: got grant=%b take=%b eng_rst=%b want 0000/0/0", grant, take, eng_rst); end
  endtask

  task automatic test_reset_mid_run();
    int k, takes, clears;
    logic fr;
    logic [NREQ-1:0] fg;
    setPat(1, 16'h0015);
    req = 4'b0010;
    takes = 0;
    k = 0;
    while (takes < 5 && k < 20) begin
      step();
      k++;
      if (take) takes++;
    end
    checks++; if (takes !== 5 || grant !== 4'b0010) begin errors++; $display("[TB] FAIL rstrun_reach: got takes=%0d grant=%b want 5/0010", takes, grant); end
    checks++; if (eng_din !== 1'b1) begin errors++; $display("[TB] FAIL rstrun_din: got %b want 1", eng_din); end
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || take !== 1'b0 || eng_din !== 1'b0 || eng_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL rstrun_immediate: got grant=%b take=%b din=%b eng_rst=%b done=%b want 0000/0/0/1/0", grant, take, eng_din, eng_rst, done); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (grant !== 4'b0000 || take !== 1'b0 || eng_rst !== 1'b1 || done_id !== 3'd0 || result !== 1'b0) begin errors++; $display("[TB] FAIL rstrun_hold%0d: got grant=%b take=%b eng_rst=%b id=%0d res=%b", c, grant, take, eng_rst, done_id, result); end
    end
    setPat(1, 16'h0080);
    rst = 1'b0;
    waitDone(0, k, takes, clears, fr, fg);
    checks++; if (k !== 11 || takes !== 8 || clears !== 1) begin errors++; $display("[TB] FAIL rstrun_fresh: got k=%0d takes=%0d clears=%0d want 11/8/1", k, takes, clears); end
    checks++; if (done_id !== 3'd1 || result !== 1'b1) begin errors++; $display("[TB] FAIL rstrun_done: got id=%0d res=%b want 1/1", done_id, result); end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rstrun_release: got %b want 0000", grant); end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    din_bus = '0;
    engState = 2'd0;
    for (int i = 0; i < NREQ; i++) setPat(i, 16'h0000);
    @(negedge clk);
    test_reset();
    test_single();
    test_even_parity();
    test_round_robin();
    test_fairness();
    test_drop_mid_burst();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
